// File: rtl/zona_arbitro.sv
// zona_arbitro: power-budget arbiter for multi-zone lighting.
// Grants at most MAX_ACTIVE zones at once. New grants go round-robin,
// a minimum on-time prevents relay chatter, and an optional maximum
// on-time lets a long-running zone be preempted while others are waiting.
//
// Request/grant contract: req[i] is a level request. grant[i] is a
// registered relay enable. While grant[i] is high and the zone's on-timer
// is below MIN_ON_T, the grant is held no matter what req[i] does. Once
// the timer reaches MIN_ON_T, dropping req[i] releases the grant on the
// next edge.
module zona_arbitro #(
  parameter int N_ZONES     = 4,
  parameter int MAX_ACTIVE  = 2,
  parameter int CLKS_PER_MS = 1,
  parameter int MIN_ON_T    = 1000,
  parameter int MAX_ON_T    = 60000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_ZONES-1:0]             req,
  output logic [N_ZONES-1:0]             grant,
  output logic [N_ZONES-1:0]             waiting,
  output logic [$clog2(N_ZONES+1)-1:0]   active_cnt,
  output logic                           preempt_pulse
);

  localparam int CW  = $clog2(N_ZONES + 1);
  localparam int PW  = $clog2(N_ZONES);
  localparam int SAT = (MIN_ON_T > MAX_ON_T) ? MIN_ON_T : MAX_ON_T;
  localparam int TW  = $clog2(SAT + 2);
  localparam int SW  = $clog2(CLKS_PER_MS + 1);

  localparam logic [TW-1:0] MIN_V = TW'(MIN_ON_T);
  localparam logic [TW-1:0] MAX_V = TW'(MAX_ON_T);
  localparam logic [TW-1:0] SAT_V = TW'(SAT);
  localparam logic [SW-1:0] PS_LAST = SW'(CLKS_PER_MS - 1);
  localparam logic [CW-1:0] CAP = CW'(MAX_ACTIVE);

  logic [SW-1:0]      presc;
  logic               ms_tick;
  logic [TW-1:0]      on_tmr [N_ZONES];
  logic [PW-1:0]      rr_ptr;

  logic [N_ZONES-1:0] rel_mask;
  logic [N_ZONES-1:0] pre_mask;
  logic [N_ZONES-1:0] win_mask;
  logic [N_ZONES-1:0] grant_n;
  logic               pre_fire;
  logic               can_grant;
  logic [PW-1:0]      win_idx;
  logic               hi_found;
  logic [PW-1:0]      hi_idx;
  logic [PW-1:0]      lo_idx;
  logic [PW-1:0]      pre_idx;
  logic               pre_found;

  assign ms_tick = (presc == PS_LAST);
  assign waiting = req & ~grant;

  // Population count of the registered grant vector.
  always_comb begin
    active_cnt = '0;
    for (int i = 0; i < N_ZONES; i++) begin
      active_cnt = active_cnt + CW'(grant[i]);
    end
  end

  // Release, preemption and round-robin winner selection from registered state.
  always_comb begin
    rel_mask  = '0;
    pre_found = 1'b0;
    pre_idx   = '0;
    hi_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    for (int i = N_ZONES - 1; i >= 0; i--) begin
      // Normal release: zone in RUN with request gone.
      if (grant[i] && (on_tmr[i] >= MIN_V) && !req[i]) rel_mask[i] = 1'b1;
      // Descending scan leaves the lowest-index candidate in place.
      if (grant[i] && (on_tmr[i] >= MAX_V)) begin
        pre_found = 1'b1;
        pre_idx   = PW'(i);
      end
      if (waiting[i]) begin
        lo_idx = PW'(i);
        if (PW'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = PW'(i);
        end
      end
    end
    win_idx   = hi_found ? hi_idx : lo_idx;
    pre_fire  = (MAX_ON_T != 0) && (active_cnt == CAP) && (|waiting) && pre_found;
    pre_mask  = pre_fire ? (N_ZONES'(1) << pre_idx) : '0;
    // Capacity is judged on registered grants only; freed slots wait one edge.
    can_grant = (active_cnt < CAP) && (|waiting);
    win_mask  = can_grant ? (N_ZONES'(1) << win_idx) : '0;
    grant_n   = (grant & ~rel_mask & ~pre_mask) | win_mask;
  end

  // Millisecond prescaler.
  always_ff @(posedge clk) begin
    if (rst || ms_tick) presc <= '0;
    else                presc <= presc + SW'(1);
  end

  // Grant vector, round-robin pointer and preemption pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant         <= '0;
      rr_ptr        <= '0;
      preempt_pulse <= 1'b0;
    end else begin
      grant         <= grant_n;
      preempt_pulse <= pre_fire;
      if (can_grant) begin
        rr_ptr <= (win_idx == PW'(N_ZONES - 1)) ? '0 : win_idx + PW'(1);
      end
    end
  end

  // Per-zone on-timers: cleared on grant rise, count ms ticks, saturate.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_ZONES; i++) begin
      if (rst) begin
        on_tmr[i] <= '0;
      end else if (grant_n[i] && !grant[i]) begin
        on_tmr[i] <= '0;
      end else if (grant[i] && ms_tick && (on_tmr[i] != SAT_V)) begin
        on_tmr[i] <= on_tmr[i] + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_zona_arbitro.sv
// tb_zona_arbitro: directed scenarios plus random request traffic, checked
// every cycle against a per-zone behavioural model of the arbitration rules.
module tb_zona_arbitro;

  localparam int NZ   = 4;
  localparam int MAXA = 2;
  localparam int CPM  = 1;
  localparam int MINT = 3;
  localparam int MAXT = 10;
  localparam int SATT = (MINT > MAXT) ? MINT : MAXT;

  // clock / reset
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NZ-1:0] req = '0;
  logic [NZ-1:0] grant;
  logic [NZ-1:0] waiting;
  logic [2:0]    active_cnt;
  logic          preempt_pulse;

  always #5 clk = ~clk;

  zona_arbitro #(
    .N_ZONES(NZ), .MAX_ACTIVE(MAXA), .CLKS_PER_MS(CPM),
    .MIN_ON_T(MINT), .MAX_ON_T(MAXT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .waiting(waiting),
    .active_cnt(active_cnt), .preempt_pulse(preempt_pulse)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one entry per zone, integer timers, plain loops.
  bit [NZ-1:0] m_g;
  int          m_tmr [NZ];
  int          m_rr;
  int          m_ps;
  bit          m_pre;

  task automatic model_step(input bit [NZ-1:0] r, input bit rs);
    bit          tick;
    int          cnt;
    bit [NZ-1:0] wv;
    bit [NZ-1:0] nxt;
    int          pz;
    int          w;
    if (rs) begin
      m_g = '0; m_rr = 0; m_ps = 0; m_pre = 0;
      for (int i = 0; i < NZ; i++) m_tmr[i] = 0;
      return;
    end
    tick = (m_ps == CPM - 1);
    m_ps = tick ? 0 : m_ps + 1;
    cnt = 0;
    for (int i = 0; i < NZ; i++) cnt += m_g[i];
    wv  = r & ~m_g;
    nxt = m_g;
    for (int i = 0; i < NZ; i++)
      if (m_g[i] && m_tmr[i] >= MINT && !r[i]) nxt[i] = 0;
    pz = -1;
    if (MAXT != 0 && cnt == MAXA && wv != 0)
      for (int i = NZ - 1; i >= 0; i--)
        if (m_g[i] && m_tmr[i] >= MAXT) pz = i;
    if (pz >= 0) nxt[pz] = 0;
    m_pre = (pz >= 0);
    w = -1;
    if (cnt < MAXA)
      for (int k = NZ - 1; k >= 0; k--)
        if (wv[(m_rr + k) % NZ]) w = (m_rr + k) % NZ;
    for (int i = 0; i < NZ; i++)
      if (nxt[i] && m_g[i] && tick && m_tmr[i] < SATT) m_tmr[i]++;
    if (w >= 0) begin
      nxt[w]   = 1;
      m_tmr[w] = 0;
      m_rr     = (w + 1) % NZ;
    end
    m_g = nxt;
  endtask

  // driver: apply inputs, advance model and DUT one edge, compare outputs
  task automatic cycle(input logic [NZ-1:0] r, input logic rs);
    int ec;
    req = r;
    rst = rs;
    model_step(r, rs);
    @(posedge clk);
    #1;
    ec = 0;
    for (int i = 0; i < NZ; i++) ec += m_g[i];
    check("grant", 32'(grant), 32'(m_g));
    check("waiting", 32'(waiting), 32'(r & ~m_g));
    check("active_cnt", 32'(active_cnt), 32'(ec));
    check("preempt_pulse", 32'(preempt_pulse), 32'(m_pre));
    check("cap_limit", 32'(active_cnt <= 3'(MAXA)), 32'd1);
  endtask

  task automatic do_reset();
    cycle('0, 1'b1);
    cycle('0, 1'b1);
  endtask

  initial begin
    logic [NZ-1:0] r;
    // reset then idle
    do_reset();
    check("rst_grant", 32'(grant), 32'h0);
    for (int i = 0; i < 20; i++) cycle(4'b0000, 1'b0);
    check("idle_grant", 32'(grant), 32'h0);
    check("idle_cnt", 32'(active_cnt), 32'h0);

    // all four request at once
    do_reset();
    cycle(4'b1111, 1'b0);
    check("all_c1", 32'(grant), 32'b0001);
    cycle(4'b1111, 1'b0);
    check("all_c2", 32'(grant), 32'b0011);
    cycle(4'b1111, 1'b0);
    check("all_c3", 32'(grant), 32'b0011);
    check("all_wait", 32'(waiting), 32'b1100);

    // request dropped during the hold time
    do_reset();
    cycle(4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0);
    check("hold_kept", 32'(grant), 32'b0001);
    cycle(4'b0000, 1'b0);
    check("hold_rel", 32'(grant), 32'b0000);

    // preemption at MAX_ON_T
    do_reset();
    for (int i = 0; i < 11; i++) cycle(4'b0111, 1'b0);
    check("pre_before", 32'(grant), 32'b0011);
    check("pre_nopulse", 32'(preempt_pulse), 32'h0);
    cycle(4'b0111, 1'b0);
    check("pre_grant", 32'(grant), 32'b0010);
    check("pre_pulse", 32'(preempt_pulse), 32'h1);
    check("pre_wait", 32'(waiting), 32'b0101);
    cycle(4'b0111, 1'b0);
    check("pre_regrant", 32'(grant), 32'b0110);

    // release and new request on the same cycle at full capacity
    do_reset();
    for (int i = 0; i < 5; i++) cycle(4'b0011, 1'b0);
    cycle(4'b1001, 1'b0);
    check("swap_k1", 32'(grant), 32'b0001);
    cycle(4'b1001, 1'b0);
    check("swap_k2", 32'(grant), 32'b1001);

    // reset mid-operation
    do_reset();
    cycle(4'b0011, 1'b0);
    cycle(4'b0011, 1'b0);
    cycle(4'b0011, 1'b1);
    check("midrst", 32'(grant), 32'b0000);
    cycle(4'b0011, 1'b0);
    check("midrst_r1", 32'(grant), 32'b0001);
    cycle(4'b0011, 1'b0);
    check("midrst_r2", 32'(grant), 32'b0011);

    // random traffic: requests persist for a while so timers can mature
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r = NZ'($urandom_range(0, 15));
      cycle(r, ($urandom_range(0, 399) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
